// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//
// Shares one multi-slice ALU between N_REQ requesters. A round-robin arbiter
// picks one pending request, its operands and opcode are registered onto the
// ALU inputs, the result is captured after ALU_LAT cycles and returned tagged
// with the requester id.
//
// Handshake rules, used on both sides of this block:
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A source keeps valid and its payload stable until that transfer.
//   ready may depend combinationally on valid.
//   Request side: each requester has its own valid bit. req_ready is one-hot
//   or zero and is only ever raised in IDLE.
//   Response side: rsp_valid stays high with rsp_* stable until rsp_ready.
//
// Ports:
//   clk, arst          clock, asynchronous active-high reset
//   req_valid/ready    per-requester handshake (N_REQ bits each)
//   req_a, req_b       packed operands, requester i at [i*DW +: DW]
//   req_sel            packed opcodes, requester i at [i*3 +: 3]
//   alu_a/b/select     registered ALU inputs, held between operations
//   alu_out/carry_out/flags   ALU results, sampled at the end of EXEC
//   rsp_valid/ready    response handshake
//   rsp_id/out/carry/flags    captured response, held after the handshake
//   busy               high whenever the FSM is not in IDLE

module alu_rr_scheduler #(
    parameter int WIDTH   = 4,
    parameter int N_ALU   = 4,
    parameter int N_REQ   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                               clk,
    input  logic                               arst,
    input  logic [N_REQ-1:0]                   req_valid,
    output logic [N_REQ-1:0]                   req_ready,
    input  logic [N_REQ*WIDTH*N_ALU-1:0]       req_a,
    input  logic [N_REQ*WIDTH*N_ALU-1:0]       req_b,
    input  logic [N_REQ*3-1:0]                 req_sel,
    output logic [WIDTH*N_ALU-1:0]             alu_a,
    output logic [WIDTH*N_ALU-1:0]             alu_b,
    output logic [2:0]                         alu_select,
    input  logic [WIDTH*N_ALU*8-1:0]           alu_out,
    input  logic                               alu_carry_out,
    input  logic [2:0]                         alu_flags,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [$clog2(N_REQ)-1:0]           rsp_id,
    output logic [WIDTH*N_ALU*8-1:0]           rsp_out,
    output logic                               rsp_carry,
    output logic [2:0]                         rsp_flags,
    output logic                               busy
);

    localparam int DW  = WIDTH * N_ALU;
    localparam int IDW = $clog2(N_REQ);
    localparam int LCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [IDW-1:0]   ptr_q;       // last granted requester
    logic [IDW-1:0]   grant_q;     // requester currently being served
    logic [LCW-1:0]   lat_cnt;

    logic             grant_found;
    logic [IDW-1:0]   grant_id;

    logic             issue;       // grant accepted this cycle
    logic             capture;     // last EXEC cycle, sample ALU outputs
    logic             rsp_done;    // response handed off this cycle

    // First set request bit strictly after the pointer, wrapping around.
    // Starting one past the last grant is what makes the order cyclic.
    function automatic logic [IDW:0] pick_grant(
        input logic [N_REQ-1:0] valid,
        input logic [IDW-1:0]   ptr
    );
        logic           found;
        logic [IDW-1:0] g;
        int             idx;
        found = 1'b0;
        g     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && valid[idx]) begin
                found = 1'b1;
                g     = IDW'(idx);
            end
        end
        return {found, g};
    endfunction

    always_comb begin
        {grant_found, grant_id} = pick_grant(req_valid, ptr_q);
    end

    // FSM state register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and per-cycle strobes
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        capture  = 1'b0;
        rsp_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    issue   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (lat_cnt == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                // rsp_valid is always 1 in RESP, so rsp_ready alone completes it.
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The reset term keeps req_ready low while arst is held, even if
    // requests are already pending and the FSM sits in IDLE.
    always_comb begin
        req_ready = '0;
        if (issue && !arst) begin
            req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
        end
    end

    assign busy = (state_q != IDLE);

    // Datapath registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ptr_q      <= IDW'(N_REQ - 1);
            grant_q    <= '0;
            lat_cnt    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_out    <= '0;
            rsp_carry  <= 1'b0;
            rsp_flags  <= '0;
        end else begin
            if (issue) begin
                alu_a      <= req_a[grant_id*DW +: DW];
                alu_b      <= req_b[grant_id*DW +: DW];
                alu_select <= req_sel[grant_id*3 +: 3];
                grant_q    <= grant_id;
                ptr_q      <= grant_id;
                lat_cnt    <= LCW'(ALU_LAT - 1);
            end
            if (state_q == EXEC && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (capture) begin
                rsp_out   <= alu_out;
                rsp_carry <= alu_carry_out;
                rsp_flags <= alu_flags;
                rsp_id    <= grant_q;
                rsp_valid <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler: one instance with ALU_LAT=1 and one with
// ALU_LAT=3, each driven by a behavioural ALU (0 add, 1 sub, 2 and, 3 mult).

module tb_alu_rr_scheduler;

    localparam int DW  = 16;
    localparam int RW  = 128;
    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int SBW = IDW + RW;

    logic clk;
    logic arst;

    // ALU_LAT = 1 instance
    logic [NR-1:0]    req_valid, req_ready;
    logic [NR*DW-1:0] req_a, req_b;
    logic [NR*3-1:0]  req_sel;
    logic [DW-1:0]    alu_a, alu_b;
    logic [2:0]       alu_select;
    logic [RW-1:0]    alu_out;
    logic             alu_carry_out;
    logic [2:0]       alu_flags;
    logic             rsp_valid, rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [RW-1:0]    rsp_out;
    logic             rsp_carry;
    logic [2:0]       rsp_flags;
    logic             busy;

    // ALU_LAT = 3 instance
    logic [NR-1:0]    l3_req_valid, l3_req_ready;
    logic [NR*DW-1:0] l3_req_a, l3_req_b;
    logic [NR*3-1:0]  l3_req_sel;
    logic [DW-1:0]    l3_alu_a, l3_alu_b;
    logic [2:0]       l3_alu_select;
    logic [RW-1:0]    l3_alu_out;
    logic             l3_alu_carry_out;
    logic [2:0]       l3_alu_flags;
    logic             l3_rsp_valid, l3_rsp_ready;
    logic [IDW-1:0]   l3_rsp_id;
    logic [RW-1:0]    l3_rsp_out;
    logic             l3_rsp_carry;
    logic [2:0]       l3_rsp_flags;
    logic             l3_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [SBW-1:0] exp_q[$];

    alu_rr_scheduler #(.WIDTH(4), .N_ALU(4), .N_REQ(NR), .ALU_LAT(1)) u_dut (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_carry(rsp_carry), .rsp_flags(rsp_flags),
        .busy(busy)
    );

    alu_rr_scheduler #(.WIDTH(4), .N_ALU(4), .N_REQ(NR), .ALU_LAT(3)) u_dut_l3 (
        .clk(clk), .arst(arst),
        .req_valid(l3_req_valid), .req_ready(l3_req_ready),
        .req_a(l3_req_a), .req_b(l3_req_b), .req_sel(l3_req_sel),
        .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_select(l3_alu_select),
        .alu_out(l3_alu_out), .alu_carry_out(l3_alu_carry_out), .alu_flags(l3_alu_flags),
        .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_id(l3_rsp_id),
        .rsp_out(l3_rsp_out), .rsp_carry(l3_rsp_carry), .rsp_flags(l3_rsp_flags),
        .busy(l3_busy)
    );

    // Behavioural ALU: returns {carry, flags, out}
    function automatic logic [RW+3:0] alu_model(input logic [DW-1:0] a,
                                                input logic [DW-1:0] b,
                                                input logic [2:0] s);
        logic [RW-1:0] o;
        logic          c;
        logic [DW:0]   t;
        o = '0;
        c = 1'b0;
        case (s)
            3'd0: begin t = {1'b0, a} + {1'b0, b}; o[DW-1:0] = t[DW-1:0]; c = t[DW]; end
            3'd1: begin t = {1'b0, a} - {1'b0, b}; o[DW-1:0] = t[DW-1:0]; c = t[DW]; end
            3'd2: o[DW-1:0] = a & b;
            3'd3: o[2*DW-1:0] = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
            default: o = '0;
        endcase
        return {c, (a > b), (a == b), (a < b), o};
    endfunction

    assign {alu_carry_out, alu_flags, alu_out}          = alu_model(alu_a, alu_b, alu_select);
    assign {l3_alu_carry_out, l3_alu_flags, l3_alu_out} = alu_model(l3_alu_a, l3_alu_b, l3_alu_select);

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking task
    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted response must match the head of exp_q.
    always @(negedge clk) begin
        if (!arst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_rsp", 128'(rsp_id), 128'(0));
                check("sb_unexpected_rsp_flag", 128'(1), 128'(0));
            end else begin
                logic [SBW-1:0] e;
                e = exp_q.pop_front();
                check("sb_rsp_id", 128'(rsp_id), 128'(e[SBW-1 -: IDW]));
                check("sb_rsp_out", rsp_out, e[RW-1:0]);
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        step();
        step();
        arst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [2:0] s);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_sel[i*3 +: 3] = s;
    endtask

    task automatic push_exp(input int id, input logic [RW-1:0] out);
        exp_q.push_back({IDW'(id), out});
    endtask

    initial begin
        arst = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b1;
        l3_req_valid = '0; l3_req_a = '0; l3_req_b = '0; l3_req_sel = '0; l3_rsp_ready = 1'b1;

        // ---- reset state
        arst = 1'b1;
        #2;
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_alu_a", 128'(alu_a), 128'(0));
        check("rst_alu_select", 128'(alu_select), 128'(0));
        check("rst_rsp_out", rsp_out, 128'(0));
        do_reset();

        // ---- 1: single request from requester 2, 5 + 3
        set_req(2, 16'h0005, 16'h0003, 3'd0);
        req_valid = 4'b0100;
        #1;
        check("t1_req_ready", 128'(req_ready), 128'(4'b0100));
        check("t1_busy_idle", 128'(busy), 128'(0));
        push_exp(2, 128'd8);
        step();
        req_valid = '0;
        check("t1_alu_a", 128'(alu_a), 128'(16'd5));
        check("t1_alu_b", 128'(alu_b), 128'(16'd3));
        check("t1_busy_exec", 128'(busy), 128'(1));
        check("t1_no_rsp_yet", 128'(rsp_valid), 128'(0));
        step();
        check("t1_rsp_valid", 128'(rsp_valid), 128'(1));
        check("t1_rsp_id", 128'(rsp_id), 128'(2));
        check("t1_rsp_out", rsp_out, 128'd8);
        check("t1_rsp_carry", 128'(rsp_carry), 128'(0));
        check("t1_rsp_flags", 128'(rsp_flags), 128'(3'b100));
        step();
        check("t1_busy_done", 128'(busy), 128'(0));
        check("t1_rsp_valid_low", 128'(rsp_valid), 128'(0));
        check("t1_rsp_out_held", rsp_out, 128'd8);

        // ---- 2: all four valid, strictly cyclic from requester 0
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 16'(i + 1), 16'd10, 3'd0);
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            check("t2_grant", 128'(req_ready), 128'(4'b0001 << (g % NR)));
            push_exp(g % NR, 128'(g % NR + 11));
            step(); step(); step();
        end

        // ---- 3: pointer wrap, grant 1 then only 0 and 3 valid
        req_valid = 4'b0010;
        #1;
        check("t3_grant1", 128'(req_ready), 128'(4'b0010));
        push_exp(1, 128'd12);
        step();
        req_valid = 4'b1001;
        step(); step();
        check("t3_grant3", 128'(req_ready), 128'(4'b1000));
        push_exp(3, 128'd14);
        step(); step(); step();
        check("t3_grant0", 128'(req_ready), 128'(4'b0001));
        push_exp(0, 128'd11);
        step();
        req_valid = '0;
        step(); step();

        // ---- 4: backpressure with requester 1 kept valid, 9 - 4
        set_req(1, 16'd9, 16'd4, 3'd1);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        check("t4_grant", 128'(req_ready), 128'(4'b0010));
        push_exp(1, 128'd5);
        step(); step();
        check("t4_rsp_valid", 128'(rsp_valid), 128'(1));
        check("t4_rsp_out", rsp_out, 128'd5);
        for (int c = 0; c < 5; c++) begin
            step();
            check("t4_hold_valid", 128'(rsp_valid), 128'(1));
            check("t4_hold_id", 128'(rsp_id), 128'(1));
            check("t4_hold_out", rsp_out, 128'd5);
            check("t4_hold_ready", 128'(req_ready), 128'(0));
            check("t4_hold_busy", 128'(busy), 128'(1));
        end
        rsp_ready = 1'b1;
        push_exp(1, 128'd5);
        step();
        check("t4_regrant", 128'(req_ready), 128'(4'b0010));
        step();
        req_valid = '0;
        step(); step();

        // ---- 5: ALU_LAT = 3, requester 0, 6 * 7
        l3_req_a[15:0]  = 16'd6;
        l3_req_b[15:0]  = 16'd7;
        l3_req_sel[2:0] = 3'd3;
        l3_req_valid = 4'b0001;
        #1;
        check("t5_grant", 128'(l3_req_ready), 128'(4'b0001));
        step();
        l3_req_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            check("t5_alu_a_stable", 128'(l3_alu_a), 128'(16'd6));
            check("t5_no_rsp", 128'(l3_rsp_valid), 128'(0));
            step();
        end
        check("t5_rsp_valid", 128'(l3_rsp_valid), 128'(1));
        check("t5_rsp_out", l3_rsp_out, 128'd42);
        step();
        check("t5_busy_done", 128'(l3_busy), 128'(0));

        // ---- 6: reset during EXEC drops the op
        set_req(1, 16'd1, 16'd1, 3'd0);
        set_req(0, 16'd2, 16'd3, 3'd0);
        set_req(2, 16'd4, 16'd4, 3'd0);
        req_valid = 4'b0010;
        #1;
        check("t6_grant", 128'(req_ready), 128'(4'b0010));
        step();
        req_valid = 4'b0101;
        check("t6_in_exec", 128'(busy), 128'(1));
        arst = 1'b1;
        #1;
        check("t6_rst_busy", 128'(busy), 128'(0));
        check("t6_rst_alu_a", 128'(alu_a), 128'(0));
        check("t6_rst_req_ready", 128'(req_ready), 128'(0));
        check("t6_rst_rsp_valid", 128'(rsp_valid), 128'(0));
        step();
        check("t6_rst_no_rsp", 128'(rsp_valid), 128'(0));
        arst = 1'b0;
        #1;
        check("t6_first_after_rst", 128'(req_ready), 128'(4'b0001));
        push_exp(0, 128'd5);
        step();
        req_valid = '0;
        step(); step(); step();

        check("sb_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Time bound in case a step sequence ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
